// File: rtl/div_rem_unit.sv
// Radix-2 restoring divider/remainder for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle, then pulses oReady for one cycle.
module div_rem_unit #(
   parameter int XLEN  = 32,
   parameter int NITER = 32
) (
   input  logic            iCLK,
   input  logic            iRST_n,
   input  logic            iStart,
   input  logic            iKill,
   input  logic [2:0]      iFunct3,
   input  logic [XLEN-1:0] iA,
   input  logic [XLEN-1:0] iB,
   output logic [XLEN-1:0] oResult,
   output logic            oReady,
   output logic            oBusy
);

   localparam int CW = $clog2(NITER);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t state, stateNext;

   logic [XLEN:0]   rem, remNext;
   logic [XLEN-1:0] quo, quoNext;
   logic [XLEN-1:0] divisor, divisorNext;
   logic [CW-1:0]   count, countNext;
   logic            qneg, qnegNext;
   logic            rneg, rnegNext;
   logic            opRem, opRemNext;
   logic [XLEN-1:0] resultNext;
   logic            readyNext;
   logic            busyNext;

   logic            isSigned;
   logic            signA;
   logic            signB;
   logic [XLEN-1:0] magA;
   logic [XLEN-1:0] magB;
   logic            divZero;
   logic            overflow;
   logic [XLEN+1:0] trial;
   logic [XLEN-1:0] fixVal;

   assign isSigned = ~iFunct3[0];
   assign signA    = isSigned & iA[XLEN-1];
   assign signB    = isSigned & iB[XLEN-1];
   assign magA     = signA ? -iA : iA;
   assign magB     = signB ? -iB : iB;
   assign divZero  = (iB == '0);
   assign overflow = isSigned
                   & (iA == {1'b1, {(XLEN-1){1'b0}}})
                   & (&iB);

   // Shifted remainder can exceed 2^32, so the trial keeps a spare sign bit.
   assign trial = {rem, quo[XLEN-1]} - {2'b00, divisor};

   assign fixVal = opRem
                 ? (rneg ? -rem[XLEN-1:0] : rem[XLEN-1:0])
                 : (qneg ? -quo : quo);

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext   = state;
      remNext     = rem;
      quoNext     = quo;
      divisorNext = divisor;
      countNext   = count;
      qnegNext    = qneg;
      rnegNext    = rneg;
      opRemNext   = opRem;
      resultNext  = oResult;
      readyNext   = 1'b0;
      busyNext    = oBusy;
      if (iKill) begin
         stateNext = IDLE;
         busyNext  = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (iStart && iFunct3[2]) begin
                  if (divZero) begin
                     resultNext = iFunct3[1] ? iA : '1;
                     readyNext  = 1'b1;
                     stateNext  = DONE;
                  end else if (overflow) begin
                     resultNext = iFunct3[1] ? '0 : iA;
                     readyNext  = 1'b1;
                     stateNext  = DONE;
                  end else begin
                     remNext     = '0;
                     quoNext     = magA;
                     divisorNext = magB;
                     countNext   = '0;
                     qnegNext    = signA ^ signB;
                     rnegNext    = signA;
                     opRemNext   = iFunct3[1];
                     busyNext    = 1'b1;
                     stateNext   = CALC;
                  end
               end
            end
            CALC: begin
               quoNext = {quo[XLEN-2:0], ~trial[XLEN+1]};
               remNext = trial[XLEN+1]
                       ? {rem[XLEN-1:0], quo[XLEN-1]}
                       : trial[XLEN:0];
               countNext = count + 1'b1;
               if (count == CW'(NITER-1)) begin
                  stateNext = FIX;
               end
            end
            FIX: begin
               resultNext = fixVal;
               readyNext  = 1'b1;
               busyNext   = 1'b0;
               stateNext  = DONE;
            end
            DONE: begin
               stateNext = IDLE;
            end
            default: begin
               stateNext = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         rem     <= '0;
         quo     <= '0;
         divisor <= '0;
         count   <= '0;
         qneg    <= 1'b0;
         rneg    <= 1'b0;
         opRem   <= 1'b0;
         oResult <= '0;
         oReady  <= 1'b0;
         oBusy   <= 1'b0;
      end else begin
         rem     <= remNext;
         quo     <= quoNext;
         divisor <= divisorNext;
         count   <= countNext;
         qneg    <= qnegNext;
         rneg    <= rnegNext;
         opRem   <= opRemNext;
         oResult <= resultNext;
         oReady  <= readyNext;
         oBusy   <= busyNext;
      end
   end

endmodule

// File: tb/tb_div_rem_unit.sv
// Self-checking bench for div_rem_unit: directed cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_div_rem_unit;

   logic        iCLK = 1'b0;
   logic        iRST_n = 1'b0;
   logic        iStart = 1'b0;
   logic        iKill = 1'b0;
   logic [2:0]  iFunct3 = 3'b000;
   logic [31:0] iA = '0;
   logic [31:0] iB = '0;
   logic [31:0] oResult;
   logic        oReady;
   logic        oBusy;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] lastRes = '0;

   div_rem_unit #(.XLEN(32), .NITER(32)) dut (
      .iCLK    (iCLK),
      .iRST_n  (iRST_n),
      .iStart  (iStart),
      .iKill   (iKill),
      .iFunct3 (iFunct3),
      .iA      (iA),
      .iB      (iB),
      .oResult (oResult),
      .oReady  (oReady),
      .oBusy   (oBusy)
   );

   always #5 iCLK = ~iCLK;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] refModel(input logic [2:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
      int sa;
      int sb;
      sa = $signed(a);
      sb = $signed(b);
      if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return f[1] ? 32'h0 : 32'h8000_0000;
      case (f)
         3'b100:  return sa / sb;
         3'b101:  return a / b;
         3'b110:  return sa % sb;
         default: return a % b;
      endcase
   endfunction

   function automatic int refLatency(input logic [2:0] f,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
      if (b == 0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   task automatic runOp(input string tag, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b);
      int          lat;
      int          expLat;
      logic [31:0] exp;
      exp    = refModel(f, a, b);
      expLat = refLatency(f, a, b);
      @(negedge iCLK);
      iFunct3 = f;
      iA      = a;
      iB      = b;
      iStart  = 1'b1;
      lat     = 0;
      do begin
         @(posedge iCLK);
         #1;
         lat++;
         if (lat == 1 && expLat == 34) check({tag, " busy"}, oBusy, 1);
         if (lat == 2) begin
            iA = ~a;
            iB = b + 32'd3;
         end
      end while (!oReady && lat < 40);
      check({tag, " lat"}, lat, expLat);
      check({tag, " res"}, oResult, exp);
      lastRes = exp;
      @(negedge iCLK);
      iStart = 1'b0;
      @(posedge iCLK);
      #1;
      check({tag, " pulse"}, oReady, 0);
      check({tag, " idle"}, oBusy, 0);
   endtask

   initial begin
      int          cnt;
      int          highs;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;

      repeat (2) @(posedge iCLK);
      #1;
      check("rst res", oResult, 0);
      check("rst ready", oReady, 0);
      check("rst busy", oBusy, 0);
      @(negedge iCLK);
      iRST_n = 1'b1;

      runOp("divu100_7", 3'b101, 32'd100, 32'd7);
      runOp("remu100_7", 3'b111, 32'd100, 32'd7);
      runOp("div-7_2", 3'b100, 32'hFFFF_FFF9, 32'd2);
      runOp("rem-7_2", 3'b110, 32'hFFFF_FFF9, 32'd2);
      runOp("rem-7_-2", 3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
      runOp("divu5_0", 3'b101, 32'd5, 32'd0);
      runOp("remu5_0", 3'b111, 32'd5, 32'd0);
      runOp("div_min_0", 3'b100, 32'h8000_0000, 32'd0);
      runOp("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
      runOp("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
      runOp("divu_max", 3'b101, 32'hFFFF_FFFF, 32'd1);

      // non-div funct3 with start high must be ignored
      @(negedge iCLK);
      iFunct3 = 3'b001;
      iStart  = 1'b1;
      repeat (3) @(posedge iCLK);
      #1;
      check("nodiv busy", oBusy, 0);
      check("nodiv ready", oReady, 0);
      @(negedge iCLK);
      iStart = 1'b0;

      // back-to-back with operands changed in the DONE cycle
      @(negedge iCLK);
      iFunct3 = 3'b101;
      iA      = 32'd50;
      iB      = 32'd5;
      iStart  = 1'b1;
      cnt     = 0;
      do begin
         @(posedge iCLK);
         #1;
         cnt++;
      end while (!oReady && cnt < 40);
      check("b2b first lat", cnt, 34);
      check("b2b first res", oResult, 10);
      @(negedge iCLK);
      iA  = 32'd81;
      iB  = 32'd9;
      cnt = 0;
      do begin
         @(posedge iCLK);
         #1;
         cnt++;
         if (cnt == 1) check("b2b gap", oReady, 0);
      end while (!oReady && cnt < 45);
      check("b2b second lat", cnt, 35);
      check("b2b second res", oResult, 9);
      lastRes = 32'd9;
      @(negedge iCLK);
      iStart = 1'b0;
      repeat (2) @(posedge iCLK);

      // kill in the middle of CALC, with start still high
      @(negedge iCLK);
      iFunct3 = 3'b101;
      iA      = 32'd1000;
      iB      = 32'd3;
      iStart  = 1'b1;
      repeat (21) @(posedge iCLK);
      @(negedge iCLK);
      iKill = 1'b1;
      @(posedge iCLK);
      #1;
      check("kill busy", oBusy, 0);
      @(posedge iCLK);
      #1;
      check("kill start busy", oBusy, 0);
      @(negedge iCLK);
      iKill  = 1'b0;
      iStart = 1'b0;
      highs  = 0;
      repeat (40) begin
         @(posedge iCLK);
         #1;
         if (oReady) highs++;
      end
      check("kill no ready", highs, 0);
      check("kill res kept", oResult, lastRes);

      // asynchronous reset mid-operation
      @(negedge iCLK);
      iFunct3 = 3'b101;
      iA      = 32'h1234_5678;
      iB      = 32'h11;
      iStart  = 1'b1;
      repeat (11) @(posedge iCLK);
      #2;
      iRST_n = 1'b0;
      #1;
      check("arst res", oResult, 0);
      check("arst ready", oReady, 0);
      check("arst busy", oBusy, 0);
      @(negedge iCLK);
      iStart = 1'b0;
      @(negedge iCLK);
      iRST_n = 1'b1;
      runOp("after_rst", 3'b100, 32'h1234_5678, 32'hFFFF_FFEF);

      for (int i = 0; i < 24; i++) begin
         f = 3'b100 | 3'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       a = $urandom;
            1:       a = $urandom_range(0, 500);
            2:       a = 32'h8000_0000;
            default: a = -$urandom_range(1, 500);
         endcase
         case ($urandom_range(0, 4))
            0:       b = $urandom;
            1:       b = $urandom_range(1, 20);
            2:       b = 32'd0;
            3:       b = 32'hFFFF_FFFF;
            default: b = -$urandom_range(1, 20);
         endcase
         runOp($sformatf("rnd%0d", i), f, a, b);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_rem_unit.md
# div_rem_unit

Iterative 32-bit integer divider/remainder unit for the RV32M DIV/DIVU/REM/REMU instructions, in the EX stage. It is the responder side of the EX-stage multicycle stall handshake. The hazard unit holds the whole pipeline frozen while `iStart` is high and `oReady` is low. This unit computes one radix-2 quotient bit per cycle, then pulses `oReady` for exactly one cycle so the pipeline advances with `oResult` valid.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.
- `NITER`, 32, iteration count; must equal `XLEN`.

Ports:
- `iCLK` in 1: single clock, rising edge.
- `iRST_n` in 1: asynchronous, active-low reset.
- `iStart` in 1: EX holds a div/rem instruction. Level signal, held high for the whole stall.
- `iKill` in 1: EX/MEM flush (exception). Aborts any operation in progress.
- `iFunct3` in 3: selects the operation.
  - 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU.
  - `iFunct3[2]=0` is not a div/rem op; `iStart` is ignored.
- `iA` in 32: dividend (rs1), sampled only on the start edge.
- `iB` in 32: divisor (rs2), sampled only on the start edge.
- `oResult` out 32: quotient or remainder. Valid while `oReady`=1 and held until the next start.
- `oReady` out 1: one-cycle completion pulse.
- `oBusy` out 1: high in CALC and FIX.

## Operation
- States:
  - IDLE: waits for a start.
  - CALC: runs the iterations.
  - FIX: applies sign correction.
  - DONE: presents the result.
- Start edge: in IDLE with `iStart`=1, `iFunct3[2]`=1, `iKill`=0.
  - Normal case:
    - Latch operand magnitudes. For DIV/REM, take the two's-complement absolute value of negative operands; for DIVU/REMU, use raw values.
    - Latch `qneg` = signA^signB (signed ops only) and `rneg` = signA (signed ops only).
    - Latch the op select.
    - Clear the 33-bit partial remainder and the count; go to CALC.
  - Divide by zero (`iB`=0): go directly to DONE.
    - DIV/DIVU result = 0xFFFFFFFF.
    - REM/REMU result = `iA`.
  - Signed overflow (DIV/REM with `iA`=0x80000000, `iB`=0xFFFFFFFF): go directly to DONE.
    - DIV result = 0x80000000; REM result = 0.
- CALC, restoring division, one bit per edge:
  - Shift {rem, quo} left by 1.
  - Compute trial = rem − divisor (33-bit).
  - If trial ≥ 0: rem = trial, quo[0] = 1. Otherwise quo[0] = 0.
  - Count increments by 1. At count = NITER−1 the iteration completes and the state goes to FIX.
- FIX: select the output and go to DONE.
  - DIV/DIVU: quo, negated if `qneg`.
  - REM/REMU: rem[31:0], negated if `rneg`.
- DONE: `oReady`=1 for this one cycle, then the unit returns to IDLE unconditionally.
- Back-to-back starts: if `iStart` is still high in the following IDLE cycle, it is the next instruction, so a new operation starts. Operands are resampled.
- `iKill`:
  - In any state, the next edge goes to IDLE.
  - `oReady` is not asserted for the killed operation; `oResult` keeps its previous value.
  - `iKill` together with `iStart` in IDLE: kill wins, nothing starts.
- Operand changes during CALC/FIX are ignored.

## Timing
- Reset (`iRST_n`=0, asynchronous): state = IDLE, count = 0, `oResult` = 0, `oReady` = 0, `oBusy` = 0, all internal registers = 0.
- Reset mid-operation aborts immediately; the operation is not resumed.
- Normal latency, with start edge E0:
  - CALC occupies edges E0+1 … E0+32.
  - FIX is registered at E0+33.
  - `oReady`=1 in the cycle after edge E0+33, i.e. 34 cycles after `iStart` is first high.
- Special-case latency: `oReady`=1 in the cycle after E0 (1-cycle operation).
- `oBusy` is high from E0 until the DONE edge.
- `oReady` is never high for two consecutive cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
1. DIVU `iA`=100, `iB`=7 → `oResult`=14 with `oReady` pulse exactly 34 cycles after `iStart` rises. Same operands with REMU → 2.
2. DIV `iA`=0xFFFFFFF9 (−7), `iB`=2 → 0xFFFFFFFD (−3). REM → 0xFFFFFFFF (−1). REM −7 / −2 → 0xFFFFFFFF.
3. Divide by zero:
   - DIVU 5/0 → 0xFFFFFFFF with `oReady` 1 cycle after start.
   - REMU 5/0 → 5.
   - DIV 0x80000000/0 → 0xFFFFFFFF.
4. Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0, both with 1-cycle latency.
5. Back-to-back:
   - Hold `iStart` high; first op DIVU 50/5, then change operands to 81/9 in the DONE cycle.
   - Expect 10, then 9 exactly 35 cycles later.
   - `oReady` is low between the two pulses.
6. Abort:
   - `iKill`=1 at CALC iteration 20 → IDLE next edge, no `oReady`, `oResult` unchanged.
   - `iRST_n`=0 at iteration 10 → all outputs 0 immediately.
   - A new start after reset release completes correctly.
